// File: rtl/systolic_pkg.sv
// Shared systolic-cluster constants and the array index type used by core and cluster.
package systolic_pkg;

  localparam int unsigned NUM_ARRAYS    = 8;
  localparam int unsigned SYSTOLIC_SIZE = 8;
  localparam int unsigned ARRAY_ID_BITS = (NUM_ARRAYS > 1) ? $clog2(NUM_ARRAYS) : 1;

  typedef logic [ARRAY_ID_BITS-1:0] array_id_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping mod N.
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          any_grant
);

  int unsigned idx;

  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = 32'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (!any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/systolic_array_scheduler.sv
// Shares a core's systolic arrays among its threads: one grant per cycle, round-robin
// over threads, lowest free array first, with completion routed back to the owner.
module systolic_array_scheduler #(
  parameter int unsigned THREADS_PER_BLOCK = 4,
  parameter int unsigned NUM_ARRAYS        = systolic_pkg::NUM_ARRAYS,
  parameter int unsigned ID_BITS           = (NUM_ARRAYS > 1) ? $clog2(NUM_ARRAYS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [THREADS_PER_BLOCK-1:0] req_valid,
  output logic [THREADS_PER_BLOCK-1:0] req_grant,
  output logic [ID_BITS-1:0]           grant_array_id,
  output logic [THREADS_PER_BLOCK-1:0] req_done,
  output logic [NUM_ARRAYS-1:0]        array_start,
  input  logic [NUM_ARRAYS-1:0]        array_done,
  output logic [ID_BITS:0]             busy_count,
  output logic                         all_idle,
  output logic                         err_spurious_done
);

  localparam int unsigned N  = THREADS_PER_BLOCK;
  localparam int unsigned A  = NUM_ARRAYS;
  localparam int unsigned TW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = ID_BITS + 1;

  logic [A-1:0]       free_q, free_d;
  logic [TW-1:0]      owner_q [A];
  logic [TW-1:0]      owner_d [A];
  logic [N-1:0]       holding_q, holding_d;
  logic [TW-1:0]      rr_ptr_q, rr_ptr_d;

  logic [N-1:0]       req_grant_d, req_done_d;
  logic [A-1:0]       array_start_d;
  logic [ID_BITS-1:0] grant_array_id_d;
  logic [CW-1:0]      busy_count_d;
  logic               err_d;

  logic [N-1:0]       eligible, win_oh;
  logic               any_win;
  logic [TW-1:0]      win_idx;
  logic               free_any;
  logic [ID_BITS-1:0] free_idx;
  logic [A-1:0]       done_ok;

  assign eligible = req_valid & ~holding_q;
  assign done_ok  = array_done & ~free_q;

  rr_arbiter #(.N(N)) u_rr_arbiter (
    .req       (eligible),
    .ptr       (rr_ptr_q),
    .grant     (win_oh),
    .any_grant (any_win)
  );

  // Encode the one-hot winner and pick the lowest-index free array.
  always_comb begin
    win_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (win_oh[i]) win_idx = TW'(i);
    end
    for (int k = int'(A) - 1; k >= 0; k--) begin
      if (free_q[k]) begin
        free_any = 1'b1;
        free_idx = ID_BITS'(k);
      end
    end
  end

  // Next state: completions and the grant both act on pre-edge free/holding.
  always_comb begin
    free_d           = free_q | done_ok;
    owner_d          = owner_q;
    holding_d        = holding_q;
    rr_ptr_d         = rr_ptr_q;
    req_done_d       = '0;
    req_grant_d      = '0;
    array_start_d    = '0;
    grant_array_id_d = grant_array_id;
    err_d            = err_spurious_done | (|(array_done & free_q));
    busy_count_d     = CW'(A);

    for (int k = 0; k < int'(A); k++) begin
      if (done_ok[k]) begin
        req_done_d[owner_q[k]] = 1'b1;
        holding_d[owner_q[k]]  = 1'b0;
      end
    end

    if (any_win && free_any) begin
      req_grant_d             = win_oh;
      array_start_d[free_idx] = 1'b1;
      grant_array_id_d        = free_idx;
      free_d[free_idx]        = 1'b0;
      owner_d[free_idx]       = win_idx;
      holding_d               = holding_d | win_oh;
      rr_ptr_d                = (win_idx == TW'(N - 1)) ? '0 : win_idx + TW'(1);
    end

    for (int k = 0; k < int'(A); k++) begin
      busy_count_d = busy_count_d - CW'(free_d[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      free_q            <= '1;
      holding_q         <= '0;
      rr_ptr_q          <= '0;
      for (int k = 0; k < int'(A); k++) owner_q[k] <= '0;
      req_grant         <= '0;
      req_done          <= '0;
      array_start       <= '0;
      grant_array_id    <= '0;
      busy_count        <= '0;
      all_idle          <= 1'b1;
      err_spurious_done <= 1'b0;
    end else begin
      free_q            <= free_d;
      holding_q         <= holding_d;
      rr_ptr_q          <= rr_ptr_d;
      owner_q           <= owner_d;
      req_grant         <= req_grant_d;
      req_done          <= req_done_d;
      array_start       <= array_start_d;
      grant_array_id    <= grant_array_id_d;
      busy_count        <= busy_count_d;
      all_idle          <= (busy_count_d == '0);
      err_spurious_done <= err_d;
    end
  end

endmodule

// File: tb/tb_systolic_array_scheduler.sv
// Bench for systolic_array_scheduler: directed scenarios plus random traffic vs a reference model.
module tb_systolic_array_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  always #5 clk = ~clk;

  // 4 threads x 8 arrays instance
  logic [3:0] rv8 = '0, g8, dn8;
  logic [7:0] ad8 = '0, st8;
  logic [2:0] id8;
  logic [3:0] bc8;
  logic       ai8, er8;

  // 4 threads x 2 arrays instance
  logic [3:0] rv2 = '0, g2, dn2;
  logic [1:0] ad2 = '0, st2;
  logic [0:0] id2;
  logic [1:0] bc2;
  logic       ai2, er2;

  int n_cmp = 0;
  int n_fail = 0;

  systolic_array_scheduler dut8 (
    .clk(clk), .reset(reset), .req_valid(rv8), .req_grant(g8), .grant_array_id(id8),
    .req_done(dn8), .array_start(st8), .array_done(ad8), .busy_count(bc8),
    .all_idle(ai8), .err_spurious_done(er8)
  );

  systolic_array_scheduler #(.NUM_ARRAYS(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(rv2), .req_grant(g2), .grant_array_id(id2),
    .req_done(dn2), .array_start(st2), .array_done(ad2), .busy_count(bc2),
    .all_idle(ai2), .err_spurious_done(er2)
  );

  // Reference model of the 8-array instance: arrays, owners, threads holding, next-in-line thread.
  bit         m_free [8];
  int         m_owner [8];
  bit         m_hold [4];
  int         m_rr;
  bit         m_err;
  logic [3:0] e_grant, e_done;
  logic [7:0] e_start;
  logic [2:0] e_gid;
  int         e_busy;

  task automatic model_tick(input logic rst, input logic [3:0] rv, input logic [7:0] ad);
    int win, arr, t;
    logic [3:0] nd;
    if (rst) begin
      for (int k = 0; k < 8; k++) begin m_free[k] = 1; m_owner[k] = 0; end
      for (int i = 0; i < 4; i++) m_hold[i] = 0;
      m_rr = 0; m_err = 0;
      e_grant = '0; e_done = '0; e_start = '0; e_gid = '0; e_busy = 0;
    end else begin
      win = -1; arr = -1; nd = '0;
      for (int off = 0; off < 4; off++) begin
        t = (m_rr + off) % 4;
        if (win < 0 && rv[t] && !m_hold[t]) win = t;
      end
      for (int k = 0; k < 8; k++) if (arr < 0 && m_free[k]) arr = k;
      for (int k = 0; k < 8; k++) begin
        if (ad[k]) begin
          if (m_free[k]) m_err = 1;
          else begin
            nd[m_owner[k]] = 1'b1;
            m_hold[m_owner[k]] = 0;
            m_free[k] = 1;
          end
        end
      end
      e_grant = '0; e_start = '0; e_done = nd;
      // arr was chosen from pre-edge state, so it cannot be an array freed above
      if (win >= 0 && arr >= 0 && !(ad[arr] && !m_free[arr])) begin
        e_grant[win] = 1'b1;
        e_start[arr] = 1'b1;
        e_gid = 3'(arr);
        m_free[arr] = 0; m_owner[arr] = win; m_hold[win] = 1;
        m_rr = (win + 1) % 4;
      end
      e_busy = 0;
      for (int k = 0; k < 8; k++) if (!m_free[k]) e_busy++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick(reset, rv8, ad8);
    #1;
  endtask

  task automatic do_reset();
    rv8 = '0; ad8 = '0; rv2 = '0; ad2 = '0;
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if ({g8, dn8, st8, id8, bc8, er8} !== '0 || ai8 !== 1'b1) begin
        n_fail++; $display("FAIL reset_idle8 cyc %0d: grant=%b done=%b start=%h id=%0d busy=%0d err=%b idle=%b, want all 0 idle=1",
                           c, g8, dn8, st8, id8, bc8, er8, ai8);
      end
      n_cmp++;
      if ({g2, dn2, st2, id2, bc2, er2} !== '0 || ai2 !== 1'b1) begin
        n_fail++; $display("FAIL reset_idle2 cyc %0d: grant=%b done=%b start=%b busy=%0d idle=%b, want all 0 idle=1",
                           c, g2, dn2, st2, bc2, ai2);
      end
    end
  endtask

  task automatic test_two_arrays();
    rv2 = 4'b0111;
    tick();
    n_cmp++;
    if (g2 !== 4'b0001 || id2 !== 1'b0 || st2 !== 2'b01) begin
      n_fail++; $display("FAIL two_arr_g0: grant=%b id=%0d start=%b, want 0001 0 01", g2, id2, st2);
    end
    tick();
    n_cmp++;
    if (g2 !== 4'b0010 || id2 !== 1'b1 || st2 !== 2'b10 || bc2 !== 2'd2) begin
      n_fail++; $display("FAIL two_arr_g1: grant=%b id=%0d start=%b busy=%0d, want 0010 1 10 2", g2, id2, st2, bc2);
    end
    rv2 = 4'b0100;
    tick();
    n_cmp++;
    if (g2 !== 4'b0000 || bc2 !== 2'd2 || ai2 !== 1'b0) begin
      n_fail++; $display("FAIL two_arr_wait: grant=%b busy=%0d idle=%b, want 0000 2 0", g2, bc2, ai2);
    end
    ad2 = 2'b10;
    tick();
    ad2 = 2'b00;
    n_cmp++;
    if (dn2 !== 4'b0010 || g2 !== 4'b0000 || bc2 !== 2'd1) begin
      n_fail++; $display("FAIL two_arr_done: done=%b grant=%b busy=%0d, want 0010 0000 1", dn2, g2, bc2);
    end
    tick();
    n_cmp++;
    if (g2 !== 4'b0100 || id2 !== 1'b1 || st2 !== 2'b10 || bc2 !== 2'd2) begin
      n_fail++; $display("FAIL two_arr_regrant: grant=%b id=%0d start=%b busy=%0d, want 0100 1 10 2", g2, id2, st2, bc2);
    end
    rv2 = '0;
  endtask

  task automatic test_single();
    rv8 = 4'b0100;
    tick();
    n_cmp++;
    if (g8 !== 4'b0100 || id8 !== 3'd0 || st8 !== 8'h01 || bc8 !== 4'd1 || ai8 !== 1'b0) begin
      n_fail++; $display("FAIL single_grant: grant=%b id=%0d start=%h busy=%0d idle=%b, want 0100 0 01 1 0",
                         g8, id8, st8, bc8, ai8);
    end
    rv8 = '0;
    tick();
    n_cmp++;
    if (g8 !== 4'b0000 || st8 !== 8'h00 || id8 !== 3'd0) begin
      n_fail++; $display("FAIL single_pulse: grant=%b start=%h id=%0d, want 0000 00 0(held)", g8, st8, id8);
    end
    tick(); tick();
    ad8 = 8'h01;
    tick();
    ad8 = '0;
    n_cmp++;
    if (dn8 !== 4'b0100 || bc8 !== 4'd0 || ai8 !== 1'b1) begin
      n_fail++; $display("FAIL single_done: done=%b busy=%0d idle=%b, want 0100 0 1", dn8, bc8, ai8);
    end
    tick();
    n_cmp++;
    if (dn8 !== 4'b0000) begin
      n_fail++; $display("FAIL single_done_pulse: done=%b, want 0000", dn8);
    end
  endtask

  task automatic test_all_threads();
    do_reset();
    rv8 = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (g8 !== 4'(1 << i) || id8 !== 3'(i) || st8 !== 8'(1 << i) || bc8 !== 4'(i + 1)) begin
        n_fail++; $display("FAIL all_grant%0d: grant=%b id=%0d start=%h busy=%0d, want %b %0d %h %0d",
                           i, g8, id8, st8, bc8, 4'(1 << i), i, 8'(1 << i), i + 1);
      end
    end
    tick();
    n_cmp++;
    if (g8 !== 4'b0000 || st8 !== 8'h00 || bc8 !== 4'd4) begin
      n_fail++; $display("FAIL all_no_double: grant=%b start=%h busy=%0d, want 0000 00 4", g8, st8, bc8);
    end
    rv8 = '0; ad8 = 8'h0F;
    tick();
    ad8 = '0;
    n_cmp++;
    if (dn8 !== 4'b1111 || bc8 !== 4'd0 || ai8 !== 1'b1) begin
      n_fail++; $display("FAIL all_multi_done: done=%b busy=%0d idle=%b, want 1111 0 1", dn8, bc8, ai8);
    end
    tick();
  endtask

  task automatic test_spurious();
    ad8 = 8'h20;
    tick();
    ad8 = '0;
    n_cmp++;
    if (er8 !== 1'b1 || dn8 !== 4'b0000 || bc8 !== 4'd0) begin
      n_fail++; $display("FAIL spurious: err=%b done=%b busy=%0d, want 1 0000 0", er8, dn8, bc8);
    end
    repeat (3) tick();
    n_cmp++;
    if (er8 !== 1'b1) begin
      n_fail++; $display("FAIL spurious_sticky: err=%b, want 1", er8);
    end
  endtask

  task automatic test_reset_mid();
    rv8 = 4'b0111;
    repeat (3) tick();
    n_cmp++;
    if (bc8 !== 4'd3) begin
      n_fail++; $display("FAIL mid_busy3: busy=%0d, want 3", bc8);
    end
    rv8 = '0; ad8 = 8'h01; reset = 1'b1;
    tick();
    reset = 1'b0; ad8 = '0;
    n_cmp++;
    if (bc8 !== 4'd0 || ai8 !== 1'b1 || er8 !== 1'b0 || g8 !== 4'b0000 || dn8 !== 4'b0000) begin
      n_fail++; $display("FAIL mid_reset: busy=%0d idle=%b err=%b grant=%b done=%b, want 0 1 0 0000 0000",
                         bc8, ai8, er8, g8, dn8);
    end
    rv8 = 4'b1000;
    tick();
    rv8 = '0;
    n_cmp++;
    if (g8 !== 4'b1000 || id8 !== 3'd0 || st8 !== 8'h01 || bc8 !== 4'd1) begin
      n_fail++; $display("FAIL mid_regrant: grant=%b id=%0d start=%h busy=%0d, want 1000 0 01 1", g8, id8, st8, bc8);
    end
    tick();
    n_cmp++;
    if (dn8 !== 4'b0000) begin
      n_fail++; $display("FAIL mid_dropped_done: done=%b, want 0000", dn8);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rv8 = 4'($urandom);
      ad8 = '0;
      for (int k = 0; k < 8; k++) if (!m_free[k] && $urandom_range(0, 3) == 0) ad8[k] = 1'b1;
      if ($urandom_range(0, 79) == 0) ad8[$urandom_range(0, 7)] = 1'b1;
      tick();
      n_cmp++;
      if (g8 !== e_grant || st8 !== e_start || id8 !== e_gid) begin
        n_fail++; $display("FAIL rand_grant cyc %0d: grant=%b start=%h id=%0d, want %b %h %0d",
                           c, g8, st8, id8, e_grant, e_start, e_gid);
      end
      n_cmp++;
      if (dn8 !== e_done) begin
        n_fail++; $display("FAIL rand_done cyc %0d: done=%b, want %b", c, dn8, e_done);
      end
      n_cmp++;
      if (bc8 !== 4'(e_busy) || ai8 !== (e_busy == 0) || er8 !== m_err) begin
        n_fail++; $display("FAIL rand_status cyc %0d: busy=%0d idle=%b err=%b, want %0d %b %b",
                           c, bc8, ai8, er8, e_busy, (e_busy == 0), m_err);
      end
    end
    rv8 = '0; ad8 = '0;
  endtask

  initial begin
    test_reset();
    test_two_arrays();
    test_single();
    test_all_threads();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_array_scheduler.md
Name: systolic_array_scheduler

Overview:
- Per-core scheduler that shares the core's NUM_ARRAYS systolic arrays among its THREADS_PER_BLOCK threads.
- Threads request an array with a valid/grant handshake. The scheduler grants at most one array per cycle, using round-robin across threads and lowest-index-first across free arrays.
- It pulses the granted array's start and tracks ownership. When an array reports done, it routes the completion back to the owning thread.
- Sits inside core, between the per-thread execution units and the systolic array cluster.

Parameters:
- THREADS_PER_BLOCK, 4, number of requesting threads (N).
- NUM_ARRAYS, 8, number of systolic arrays managed (A). Legal range 1..16.
- ID_BITS, $clog2(NUM_ARRAYS) (minimum 1), width of array index.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  N  thread i requests an array; held until its grant or cancelled.
- req_grant  output  N  one-cycle pulse; thread i granted.
- grant_array_id  output  ID_BITS  array index accompanying the req_grant pulse.
- req_done  output  N  one-cycle pulse; thread i's array finished.
- array_start  output  A  one-cycle pulse launching array k.
- array_done  input  A  one-cycle pulse; array k finished.
- busy_count  output  ID_BITS+1  number of arrays currently owned.
- all_idle  output  1  high when no array is owned.
- err_spurious_done  output  1  sticky; array_done seen on an unowned array.

Behaviour:
- Reset (synchronous, active-high, any time, including mid-operation):
  - all arrays free; owner table and holding flags cleared; RR pointer = 0.
  - req_grant, req_done, array_start, grant_array_id, busy_count, err_spurious_done all 0; all_idle = 1.
  - in-flight array_done pulses are dropped.
- State:
  - free[A], reset all 1.
  - owner[A] (thread index).
  - holding[N], reset 0.
  - rr_ptr (thread index).
- Eligibility: thread i is eligible in a cycle iff req_valid[i] && !holding[i]. A thread owns at most one array.
- Arbitration (cycle t, registered outputs visible at t+1):
  - If any thread is eligible and any array is free:
    - winner = first eligible thread scanning from rr_ptr upward, mod N.
    - k = lowest index with free[k] = 1.
  - On the edge ending cycle t:
    - req_grant[winner] = 1, grant_array_id = k, array_start[k] = 1.
    - free[k] = 0, owner[k] = winner, holding[winner] = 1.
    - rr_ptr = (winner + 1) mod N.
  - With no grant: rr_ptr unchanged, req_grant = 0, array_start = 0, grant_array_id holds its last value.
  - Since holding is set on the grant edge, a thread that keeps req_valid high during the grant cycle is not granted twice.
  - Dropping req_valid before the grant cancels the request with no side effects.
- Completion: array_done[k] at cycle t with free[k] = 0:
  - at t+1, req_done[owner[k]] = 1, free[k] = 1, holding[owner[k]] = 0.
  - Multiple array_done pulses in one cycle are all processed in that cycle; owners are distinct, so several req_done bits may be high together.
- Simultaneous done and grant: arbitration at cycle t uses the pre-edge free/holding values. An array freed by a done in cycle t is not grantable until cycle t+1, and its owning thread cannot be regranted in cycle t.
- Spurious done: array_done[k] with free[k] = 1 produces no req_done and no state change, and sets err_spurious_done, which is cleared only by reset.
- busy_count is registered and equals A minus popcount(free) after each edge. all_idle = (busy_count == 0).
- No starvation: a continuously requesting thread is granted within N grants once arrays free up.

Decomposition:
- Shared package systolic_pkg:
  - typedef for array id, width ID_BITS.
  - localparam defaults for NUM_ARRAYS and SYSTOLIC_SIZE, used by core and the cluster.
- Sub-module rr_arbiter (parameter N): inputs request vector and pointer; outputs one-hot grant and any_grant; purely combinational.
- Free-array selection is a priority encoder inlined in the scheduler.

Test Plan:
1. Reset, then idle for 5 cycles -> all outputs 0, all_idle = 1, busy_count = 0.
2. req_valid = 4'b0100 at cycle 1 -> cycle 2: req_grant = 4'b0100, grant_array_id = 0, array_start = 8'h01, busy_count = 1. Pulse array_done[0] at cycle 6 -> cycle 7: req_done = 4'b0100, busy_count = 0.
3. req_valid = 4'b1111 held -> grants to threads 0, 1, 2, 3 on four consecutive cycles with arrays 0, 1, 2, 3; busy_count = 4; no thread is granted twice.
4. NUM_ARRAYS = 2; threads 0, 1 and 2 request -> threads 0 and 1 get arrays 0 and 1; thread 2 waits. array_done[1] at cycle t -> thread 2 granted array 1 at t+2, not t+1.
5. array_done[5] while array 5 is free -> err_spurious_done = 1 and stays 1; req_done stays 0; busy_count unchanged.
6. Three arrays owned, then reset for one cycle -> next cycle busy_count = 0 and all_idle = 1. A subsequent request from thread 3 receives array 0.
